// File: rtl/lvds_link_sched.sv
// Host-side scheduler for one LVDS remote-IO link: round-robin arbitration, one
// outstanding 56-bit frame at a time, response timeout and two-phase calibration.
module lvds_link_sched #(
    parameter int          NREQ        = 4,
    parameter int          TIMEOUT     = 1023,
    parameter logic [31:0] CAL_PATTERN = 32'hA55A0FF0,
    parameter logic [31:0] CAL_FIXED   = 32'h080FF010
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [56*NREQ-1:0] req_frame,
    output logic [NREQ-1:0]    done,
    output logic               timeout,
    output logic [31:0]        rdata,
    input  logic               cal_start,
    output logic               link_ok,
    output logic [7:0]         err_count,
    output logic               busy,
    output logic               tx_v,
    output logic [55:0]        tx_d,
    input  logic               rx_v,
    input  logic [31:0]        rx_d
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    localparam logic [1:0]  PH_USER    = 2'd0;
    localparam logic [1:0]  PH_CAL1    = 2'd1;
    localparam logic [1:0]  PH_CAL2    = 2'd2;
    localparam logic [55:0] CAL1_FRAME = 56'h0;
    localparam logic [55:0] CAL2_FRAME = {15'h0, 1'b1, 8'h00, CAL_PATTERN};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        cal_ph_q;
    logic              cal_pend_q;
    logic [GW-1:0]     rr_ptr_q;
    logic [GW-1:0]     gnt_q;
    logic [TW-1:0]     timer_q;
    logic [31:0]       rword_q;
    logic              to_q;
    logic [NREQ-1:0]   done_q;
    logic              timeout_q;
    logic [31:0]       rdata_q;
    logic              link_ok_q;
    logic [7:0]        err_count_q;
    logic              busy_q;
    logic              tx_v_q;
    logic [55:0]       tx_d_q;

    logic [NREQ-1:0]   hi_mask_s;
    logic [NREQ-1:0]   req_hi_s;
    logic [GW-1:0]     gnt_s;
    logic [GW-1:0]     rr_next_s;
    logic [55:0]       frame_s;
    logic              fin_err_s;

    function automatic logic [GW-1:0] lowest_set(input logic [NREQ-1:0] v);
        logic [GW-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = GW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Round-robin pick: lowest requester at or above rr_ptr, else wrap to the lowest overall.
    always_comb begin
        hi_mask_s = ~((NREQ'(1) << rr_ptr_q) - NREQ'(1));
        req_hi_s  = req & hi_mask_s;
        if (|req_hi_s) begin
            gnt_s = lowest_set(req_hi_s);
        end else begin
            gnt_s = lowest_set(req);
        end
        rr_next_s = (gnt_s == GW'(NREQ - 1)) ? '0 : gnt_s + GW'(1);
        frame_s   = 56'h0;
        for (int k = 0; k < NREQ; k++) begin
            frame_s = frame_s | (req_frame[56*k +: 56] & {56{gnt_s == GW'(k)}});
        end
    end

    // Whether the transaction finishing this cycle counts as an error.
    always_comb begin
        fin_err_s = 1'b0;
        if (state_q == FIN) begin
            case (cal_ph_q)
                PH_USER: fin_err_s = to_q;
                PH_CAL1: fin_err_s = to_q || (rword_q != CAL_FIXED);
                PH_CAL2: fin_err_s = to_q || (rword_q != CAL_PATTERN);
                default: fin_err_s = 1'b0;
            endcase
        end else begin
            fin_err_s = 1'b0;
        end
    end

    // Link sequencing FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cal_ph_q    <= PH_USER;
            cal_pend_q  <= 1'b0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            timer_q     <= '0;
            rword_q     <= 32'h0;
            to_q        <= 1'b0;
            done_q      <= '0;
            timeout_q   <= 1'b0;
            rdata_q     <= 32'h0;
            link_ok_q   <= 1'b0;
            err_count_q <= 8'h00;
            busy_q      <= 1'b0;
            tx_v_q      <= 1'b0;
            tx_d_q      <= 56'h0;
        end else begin
            done_q    <= '0;
            timeout_q <= 1'b0;
            rdata_q   <= 32'h0;
            tx_v_q    <= 1'b0;
            if (cal_start) begin
                cal_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cal_pend_q) begin
                        // A cal_start on the launch cycle itself stays pending.
                        cal_pend_q <= cal_start;
                        cal_ph_q   <= PH_CAL1;
                        link_ok_q  <= 1'b0;
                        tx_d_q     <= CAL1_FRAME;
                        tx_v_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end else if (|req) begin
                        gnt_q    <= gnt_s;
                        rr_ptr_q <= rr_next_s;
                        tx_d_q   <= frame_s;
                        tx_v_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= SEND;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SEND: begin
                    timer_q <= '0;
                    busy_q  <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    busy_q <= 1'b1;
                    if (rx_v) begin
                        rword_q <= rx_d;
                        to_q    <= 1'b0;
                        state_q <= FIN;
                        if (cal_ph_q == PH_USER) begin
                            done_q  <= NREQ'(1) << gnt_q;
                            rdata_q <= rx_d;
                        end
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        rword_q <= 32'h0;
                        to_q    <= 1'b1;
                        state_q <= FIN;
                        if (cal_ph_q == PH_USER) begin
                            done_q    <= NREQ'(1) << gnt_q;
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                FIN: begin
                    if (fin_err_s) begin
                        err_count_q <= sat_inc(err_count_q);
                    end
                    if (to_q) begin
                        link_ok_q <= 1'b0;
                    end
                    case (cal_ph_q)
                        PH_CAL1: begin
                            if (!fin_err_s) begin
                                cal_ph_q <= PH_CAL2;
                                tx_d_q   <= CAL2_FRAME;
                                tx_v_q   <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= SEND;
                            end else begin
                                cal_ph_q <= PH_USER;
                                busy_q   <= 1'b0;
                                state_q  <= IDLE;
                            end
                        end
                        PH_CAL2: begin
                            link_ok_q <= !fin_err_s;
                            cal_ph_q  <= PH_USER;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end
                        default: begin
                            cal_ph_q <= PH_USER;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    endcase
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign timeout   = timeout_q;
    assign rdata     = rdata_q;
    assign link_ok   = link_ok_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;
    assign tx_v      = tx_v_q;
    assign tx_d      = tx_d_q;

endmodule

// File: tb/tb_lvds_link_sched.sv
// Bench for lvds_link_sched: a procedural transaction-level model predicts every
// output each cycle, and directed scenarios add hand-computed literal checks.
module tb_lvds_link_sched;
    localparam int          NREQ        = 4;
    localparam int          TIMEOUT     = 1023;
    localparam logic [31:0] CAL_PATTERN = 32'hA55A0FF0;
    localparam logic [31:0] CAL_FIXED   = 32'h080FF010;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [56*NREQ-1:0] req_frame = '0;
    logic [NREQ-1:0]    done;
    logic               timeout;
    logic [31:0]        rdata;
    logic               cal_start = 1'b0;
    logic               link_ok;
    logic [7:0]         err_count;
    logic               busy;
    logic               tx_v;
    logic [55:0]        tx_d;
    logic               rx_v = 1'b0;
    logic [31:0]        rx_d = 32'h0;

    lvds_link_sched #(
        .NREQ(NREQ), .TIMEOUT(TIMEOUT), .CAL_PATTERN(CAL_PATTERN), .CAL_FIXED(CAL_FIXED)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_frame(req_frame),
        .done(done), .timeout(timeout), .rdata(rdata), .cal_start(cal_start),
        .link_ok(link_ok), .err_count(err_count), .busy(busy),
        .tx_v(tx_v), .tx_d(tx_d), .rx_v(rx_v), .rx_d(rx_d)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [55:0] frm(input int i);
        logic [7:0] a;
        a = i[7:0];
        return {a, 48'hA0B0_C0D0_E000 + 48'(i)};
    endfunction

    // ---------------- model ----------------
    logic              e_tx_v;
    logic [55:0]       e_tx_d;
    logic [NREQ-1:0]   e_done;
    logic              e_timeout;
    logic [31:0]       e_rdata;
    logic              e_link_ok;
    logic [7:0]        e_err;
    logic              e_busy;

    logic [NREQ-1:0]    s_req;
    logic [56*NREQ-1:0] s_frame;
    logic               s_cal, s_rx_v;
    logic [31:0]        s_rx_d;
    bit                 m_cal_pend, prev_pend, m_abort;
    int                 m_rr, m_g;

    task automatic model_reset();
        e_tx_v = 1'b0; e_tx_d = 56'h0; e_done = '0; e_timeout = 1'b0;
        e_rdata = 32'h0; e_link_ok = 1'b0; e_err = 8'h00; e_busy = 1'b0;
        m_cal_pend = 1'b0; m_rr = 0; m_abort = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        s_req = req; s_frame = req_frame; s_cal = cal_start;
        s_rx_v = rx_v; s_rx_d = rx_d;
        prev_pend = m_cal_pend;
        if (reset) m_abort = 1'b1;
        else if (s_cal) m_cal_pend = 1'b1;
    endtask

    task automatic bump_err();
        if (e_err != 8'hFF) e_err = e_err + 8'd1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        for (int i = rr; i < NREQ; i++) if (r[i]) return i;
        for (int i = 0; i < rr; i++) if (r[i]) return i;
        return 0;
    endfunction

    // Frame goes out on the cycle after the current edge; response window is TIMEOUT+1 cycles.
    task automatic xact(input logic [55:0] f, output bit to, output logic [31:0] w);
        to = 1'b1; w = 32'h0;
        e_tx_v = 1'b1; e_tx_d = f; e_busy = 1'b1;
        step();
        if (m_abort) return;
        e_tx_v = 1'b0;
        for (int k = 0; k <= TIMEOUT; k++) begin
            step();
            if (m_abort) return;
            if (s_rx_v) begin
                to = 1'b0; w = s_rx_d;
                break;
            end
        end
    endtask

    task automatic user_xact(input int g);
        bit to;
        logic [31:0] w;
        xact(s_frame[56*g +: 56], to, w);
        if (m_abort) return;
        e_done = NREQ'(1) << g; e_timeout = to; e_rdata = to ? 32'h0 : w;
        step();
        if (m_abort) return;
        e_done = '0; e_timeout = 1'b0; e_rdata = 32'h0; e_busy = 1'b0;
        if (to) begin
            e_link_ok = 1'b0;
            bump_err();
        end
    endtask

    task automatic cal_seq();
        bit to;
        logic [31:0] w;
        e_link_ok = 1'b0;
        xact(56'h0, to, w);
        if (m_abort) return;
        step();
        if (m_abort) return;
        if (to || w != CAL_FIXED) begin
            bump_err();
            e_busy = 1'b0;
            return;
        end
        xact({15'h0, 1'b1, 8'h00, CAL_PATTERN}, to, w);
        if (m_abort) return;
        step();
        if (m_abort) return;
        if (!to && w == CAL_PATTERN) e_link_ok = 1'b1;
        else bump_err();
        e_busy = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            step();
            if (m_abort) begin
                model_reset();
            end else begin
                e_busy = 1'b0;
                if (prev_pend) begin
                    m_cal_pend = s_cal;
                    cal_seq();
                end else if (|s_req) begin
                    m_g  = pick(s_req, m_rr);
                    m_rr = (m_g + 1) % NREQ;
                    user_xact(m_g);
                end
                if (m_abort) model_reset();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_tx_v", 64'(tx_v), 64'h0);
            chk("rst_tx_d", 64'(tx_d), 64'h0);
            chk("rst_done", 64'(done), 64'h0);
            chk("rst_timeout", 64'(timeout), 64'h0);
            chk("rst_rdata", 64'(rdata), 64'h0);
            chk("rst_link_ok", 64'(link_ok), 64'h0);
            chk("rst_err_count", 64'(err_count), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
        end else begin
            chk("tx_v", 64'(tx_v), 64'(e_tx_v));
            if (e_tx_v) chk("tx_d", 64'(tx_d), 64'(e_tx_d));
            chk("done", 64'(done), 64'(e_done));
            if (e_done != '0) begin
                chk("timeout", 64'(timeout), 64'(e_timeout));
                chk("rdata", 64'(rdata), 64'(e_rdata));
            end
            chk("link_ok", 64'(link_ok), 64'(e_link_ok));
            chk("err_count", 64'(err_count), 64'(e_err));
            chk("busy", 64'(busy), 64'(e_busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_tx(input int budget, output logic [55:0] f);
        int n;
        n = 0;
        while (tx_v !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk("tx_v_seen", 64'(tx_v), 64'h1);
        f = tx_d;
    endtask

    task automatic serve(input logic [31:0] resp, input int delay, output logic [55:0] f);
        wait_tx(8, f);
        tick(1 + delay);
        rx_v = 1'b1; rx_d = resp;
        tick(1);
        rx_v = 1'b0; rx_d = 32'h0;
    endtask

    task automatic pulse_cal();
        cal_start = 1'b1;
        tick(1);
        cal_start = 1'b0;
    endtask

    initial begin
        logic [55:0] f;
        for (int i = 0; i < NREQ; i++) req_frame[56*i +: 56] = frm(i);
        tick(3);
        reset = 1'b0;
        chk("a_busy", 64'(busy), 64'h0);
        chk("a_err", 64'(err_count), 64'h0);
        chk("a_link_ok", 64'(link_ok), 64'h0);

        // Round-robin with all four requesting, frame 0 carries address 0.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(32'h100 + 32'(k), k, f);
            chk("rr_frame", 64'(f), 64'(frm(k % 4)));
            chk("rr_done", 64'(done), 64'(4'b0001 << (k % 4)));
            chk("rr_rdata", 64'(rdata), 64'(32'h100 + 32'(k)));
        end
        req = 4'b1001;
        serve(32'h200, 1, f);
        req = 4'b0000;
        chk("rr_1001_frame", 64'(f), 64'(frm(3)));
        chk("rr_1001_done", 64'(done), 64'h8);
        tick(2);
        chk("rr_idle_busy", 64'(busy), 64'h0);

        // Single request, req dropped after the grant.
        req_frame[2*56 +: 56] = 56'h05_000000001234;
        req = 4'b0100;
        tick(1);
        chk("single_tx_v", 64'(tx_v), 64'h1);
        chk("single_tx_d", 64'(tx_d), 64'h05_000000001234);
        req = 4'b0000;
        tick(1);
        rx_v = 1'b1; rx_d = 32'hDEADBEEF;
        tick(1);
        rx_v = 1'b0; rx_d = 32'h0;
        chk("single_done", 64'(done), 64'h4);
        chk("single_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("single_timeout", 64'(timeout), 64'h0);
        tick(2);

        // Calibration pass.
        pulse_cal();
        serve(CAL_FIXED, 2, f);
        chk("calp_frame1", 64'(f), 64'h0);
        chk("calp_no_done1", 64'(done), 64'h0);
        serve(CAL_PATTERN, 0, f);
        chk("calp_frame2", 64'(f), 64'h000100A55A0FF0);
        chk("calp_no_done2", 64'(done), 64'h0);
        tick(1);
        chk("calp_link_ok", 64'(link_ok), 64'h1);
        chk("calp_err", 64'(err_count), 64'h0);

        // Timeout, then a stray response.
        req = 4'b0010;
        wait_tx(8, f);
        req = 4'b0000;
        tick(TIMEOUT + 1);
        chk("to_not_early", 64'(done), 64'h0);
        tick(1);
        chk("to_done", 64'(done), 64'h2);
        chk("to_flag", 64'(timeout), 64'h1);
        chk("to_rdata", 64'(rdata), 64'h0);
        tick(1);
        chk("to_link_ok", 64'(link_ok), 64'h0);
        chk("to_err", 64'(err_count), 64'h1);
        tick(1);
        rx_v = 1'b1; rx_d = 32'h1234;
        tick(1);
        rx_v = 1'b0; rx_d = 32'h0;
        tick(2);
        chk("stray_busy", 64'(busy), 64'h0);

        // Response on the final WAIT cycle wins.
        req = 4'b0010;
        serve(32'hCAFE0001, TIMEOUT, f);
        req = 4'b0000;
        chk("last_done", 64'(done), 64'h2);
        chk("last_timeout", 64'(timeout), 64'h0);
        chk("last_rdata", 64'(rdata), 64'hCAFE0001);
        tick(2);

        // Calibration fail at phase 1.
        pulse_cal();
        serve(32'h0, 0, f);
        chk("calf_frame1", 64'(f), 64'h0);
        tick(1);
        chk("calf_err", 64'(err_count), 64'h2);
        chk("calf_link_ok", 64'(link_ok), 64'h0);
        tick(4);
        chk("calf_busy", 64'(busy), 64'h0);

        // cal_start while busy is served next, ahead of a waiting requester.
        req = 4'b0010;
        wait_tx(8, f);
        chk("hold_user_frame", 64'(f), 64'(frm(1)));
        tick(2);
        pulse_cal();
        tick(1);
        rx_v = 1'b1; rx_d = 32'h77;
        tick(1);
        rx_v = 1'b0; rx_d = 32'h0;
        chk("hold_user_done", 64'(done), 64'h2);
        serve(CAL_FIXED, 0, f);
        chk("hold_cal_first", 64'(f), 64'h0);
        serve(CAL_PATTERN, 0, f);
        chk("hold_cal_second", 64'(f), 64'h000100A55A0FF0);
        serve(32'h88, 0, f);
        req = 4'b0000;
        chk("hold_user_again", 64'(f), 64'(frm(1)));
        chk("hold_done_again", 64'(done), 64'h2);
        tick(2);
        chk("hold_link_ok", 64'(link_ok), 64'h1);

        // err_count saturation.
        for (int k = 0; k < 256; k++) begin
            pulse_cal();
            serve(32'h0, 0, f);
            tick(1);
        end
        chk("sat_err", 64'(err_count), 64'hFF);
        chk("sat_link_ok", 64'(link_ok), 64'h0);

        // Reset in WAIT with a calibration pending; late response ignored.
        req = 4'b0001;
        wait_tx(8, f);
        req = 4'b0000;
        tick(1);
        pulse_cal();
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("rw_done", 64'(done), 64'h0);
        chk("rw_busy", 64'(busy), 64'h0);
        chk("rw_err", 64'(err_count), 64'h0);
        reset = 1'b0;
        tick(2);
        rx_v = 1'b1; rx_d = 32'h55;
        tick(1);
        rx_v = 1'b0; rx_d = 32'h0;
        tick(2);
        chk("rw_after_done", 64'(done), 64'h0);
        chk("rw_after_busy", 64'(busy), 64'h0);
        chk("rw_after_link_ok", 64'(link_ok), 64'h0);
        req = 4'b1000;
        serve(32'h99, 3, f);
        req = 4'b0000;
        chk("rw_next_frame", 64'(f), 64'(frm(3)));
        chk("rw_next_done", 64'(done), 64'h8);
        chk("rw_next_rdata", 64'(rdata), 64'h99);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lvds_link_sched.md
# lvds_link_sched

Host-side scheduler for one LVDS remote-IO link. It shares a single serial request/response channel among NREQ requesters with round-robin arbitration. It sequences exactly one 56-bit request frame and its 32-bit response at a time, declares timeouts, and runs the link calibration handshake that sets `link_ok`. It sits between host logic and the host's lvds_tx/lvds_rx pair, in the same clock domain as those serializers.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 1023: cycles to wait for a response after `tx_v` before declaring a timeout.
- CAL_PATTERN, 32'hA55A0FF0: echo pattern used in calibration phase 2.
- CAL_FIXED, 32'h080FF010: required response to calibration phase 1.

Ports:
- clock  in  1  serializer-domain clock; all logic is on the posedge.
- reset  in  1  asynchronous, active-high.
- req  in  NREQ  per-requester request level.
- req_frame  in  56*NREQ  request frames, flattened; requester i uses bits [56*i+55:56*i], with [55:48] address and [47:0] payload.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- timeout  out  1  valid with `done`; 1 means no response arrived and `rdata` is 0.
- rdata  out  32  response data, valid with `done`.
- cal_start  in  1  pulse that requests a calibration sequence.
- link_ok  out  1  set when calibration passes; cleared when calibration starts, fails, or any timeout occurs.
- err_count  out  8  saturating count of timeouts and calibration mismatches.
- busy  out  1  high whenever the FSM is not in IDLE.
- tx_v  out  1  one-cycle frame strobe to lvds_tx.
- tx_d  out  56  frame to lvds_tx, valid with `tx_v`.
- rx_v  in  1  one-cycle response strobe from the receive path.
- rx_d  in  32  response word, valid with `rx_v`.

## Operation
- States: IDLE, SEND, WAIT, FIN.
- `cal_pend` flag: set by `cal_start` in any state; cleared when a calibration sequence is launched.
- `cal_ph` register: 0 means user transaction, 1 means calibration phase 1, 2 means calibration phase 2.
- IDLE with `cal_pend` set:
  - Calibration takes priority over all requesters.
  - Latch frame 56'h0, set `cal_ph`=1, clear `link_ok`, go to SEND.
- IDLE with any `req` set:
  - Grant the first set requester at or after `rr_ptr`, cyclic in index order.
  - Latch that requester's frame and index.
  - Set `rr_ptr` to grant+1 mod NREQ, go to SEND.
- IDLE with nothing pending: stay in IDLE.
- SEND: drive `tx_v`=1 and `tx_d`=latched frame for exactly one cycle, clear the timer, go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - `rx_v` latches `rx_d` and goes to FIN with ok.
  - If the timer reaches TIMEOUT without `rx_v`, go to FIN with timeout.
- FIN, user transaction (`cal_ph`=0):
  - Pulse `done[grant]`.
  - Drive `rdata` = latched word, or 0 on timeout.
  - Drive `timeout` accordingly.
  - Go to IDLE.
- FIN, calibration phase 1:
  - Response == CAL_FIXED: latch frame {8'h00, 7'h0, 1'b1, 8'h00, CAL_PATTERN}, so bit 40 = 1. Set `cal_ph`=2, go to SEND.
  - Otherwise (mismatch or timeout): `err_count`+1, `cal_ph`=0, go to IDLE. No `done` pulse.
- FIN, calibration phase 2:
  - Response == CAL_PATTERN: set `link_ok`.
  - Otherwise: `err_count`+1.
  - Then `cal_ph`=0, go to IDLE.
- A timeout in any phase increments `err_count` and clears `link_ok`.
- `err_count` saturates at 255.
- `rx_v` outside WAIT (a late or stray response) is ignored and changes no state.
- A user frame with address 0 is sent unmodified. The scheduler does not reinterpret it.
- Dropping `req` after the grant does not abort the transaction; `done` still pulses.
- Requesters must hold `req_frame` valid while `req` is high.

## Timing
- Reset values: `done`=0, `timeout`=0, `rdata`=0, `link_ok`=0, `err_count`=0, `busy`=0, `tx_v`=0, `tx_d`=0. Also state=IDLE, `rr_ptr`=0, `cal_pend`=0, `cal_ph`=0.
- `req` sampled high in IDLE at cycle t → `tx_v` at t+1.
- `rx_v` at cycle r → `done` and `rdata` at r+1 → `busy` low at r+2 → next `tx_v` no earlier than r+3.
- Timeout: if `tx_v` is at s and no `rx_v` arrives, `done` with `timeout`=1 is at s+TIMEOUT+2.
- `rx_v` on the final WAIT cycle wins over timeout.
- At most one frame is outstanding; `tx_v` strobes are at least 3 cycles apart.
- `cal_start` while busy is held pending and served at the next IDLE, ahead of requesters.
- Reset mid-transaction:
  - Everything returns to reset values immediately; no `done` is issued.
  - The pending calibration is lost.
  - An `rx_v` for the aborted frame that arrives later is ignored.

## Test plan
- Single request: `req[2]`=1, frame 56'h05_000000001234 → `tx_v` one cycle later with that frame. `rx_v` with 32'hDEADBEEF → `done`=4'b0100, `rdata`=32'hDEADBEEF, `timeout`=0.
- Round-robin: `req`=4'b1111 held → grants in order 0,1,2,3,0. With `req`=4'b1001 after a grant to 0 → next grant is 3.
- Calibration pass: `cal_start`. Respond 32'h080FF010 to frame 56'h0, then respond CAL_PATTERN to the bit-40 frame → `link_ok`=1, `err_count`=0, no `done` pulses.
- Calibration fail: phase-1 response 32'h0 → no phase-2 frame, `link_ok`=0, `err_count`=1.
- Timeout: request with no `rx_v` → `done` at `tx_v`+TIMEOUT+2 with `timeout`=1, `rdata`=0, `link_ok` cleared. A later stray `rx_v` is ignored. `rx_v` exactly on the last WAIT cycle → success.
- Reset in WAIT: assert `reset`, then release. Deliver `rx_v` → no `done`, all outputs at reset values, and the next request completes normally.
